// File: rtl/alu_multicycle_if.sv
// rtl/alu_multicycle_if.sv - operand/op request and result/flag response bundle for alu_multicycle
interface alu_multicycle_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       ALUOperation;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] ALUResult;
   logic [WIDTH-1:0] ResultHi;
   logic             Zero;
   logic             Overflow;

   // Producer/consumer side (operand muxes + EX/MEM register)
   modport master (
      output in_valid, ALUOperation, A, B, out_ready,
      input  in_ready, out_valid, ALUResult, ResultHi, Zero, Overflow
   );

   // ALU side
   modport slave (
      input  in_valid, ALUOperation, A, B, out_ready,
      output in_ready, out_valid, ALUResult, ResultHi, Zero, Overflow
   );
endinterface

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - handshaked EX-stage ALU with iterative MULU (optional DIVU under ALU_DIVIDE_EN)
module alu_multicycle #(
   parameter int WIDTH = 32
) (
   input logic              clk,
   input logic              reset,
   alu_multicycle_if.slave  bus
);
   localparam int SHW = $clog2(WIDTH);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_NOR  = 4'b0010;
   localparam logic [3:0] OP_ADD  = 4'b0011;
   localparam logic [3:0] OP_SUB  = 4'b0100;
   localparam logic [3:0] OP_SLL  = 4'b0101;
   localparam logic [3:0] OP_SRL  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_MULU = 4'b1000;
`ifdef ALU_DIVIDE_EN
   localparam logic [3:0] OP_DIVU = 4'b1001;
`endif

   typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

   state_t           state_q, state_d;
   logic             rdy_q;
   logic [SHW-1:0]   cnt_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] acc_hi_q;
   logic [WIDTH-1:0] acc_lo_q;
   logic             ovf_q;
`ifdef ALU_DIVIDE_EN
   logic [3:0]       op_q;
   logic [WIDTH:0]   div_trial;
`endif

   logic             in_ready_c;
   logic             out_valid_c;
   logic             accept;
   logic             iter_op;
   logic             last_step;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] sc_res;
   logic             sc_ovf;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] step_hi;
   logic [WIDTH-1:0] step_lo;

   assign accept    = bus.in_valid && in_ready_c;
   assign last_step = (cnt_q == '0);
   assign sum       = bus.A + bus.B;
   assign diff      = bus.A - bus.B;

`ifdef ALU_DIVIDE_EN
   assign iter_op = (bus.ALUOperation == OP_MULU) || (bus.ALUOperation == OP_DIVU);
`else
   assign iter_op = (bus.ALUOperation == OP_MULU);
`endif

   // State register; in_ready is held low until the first clock after reset release
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rdy_q   <= 1'b1;
      end
   end

   // Next-state and handshake outputs
   always_comb begin
      state_d     = state_q;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready_c = rdy_q;
            if (accept) state_d = iter_op ? ITER : DONE;
         end
         ITER: begin
            if (last_step) state_d = DONE;
         end
         DONE: begin
            out_valid_c = 1'b1;
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Single-cycle result and signed overflow from the live operands (used only at accept)
   always_comb begin
      sc_res = '0;
      sc_ovf = 1'b0;
      case (bus.ALUOperation)
         OP_AND: sc_res = bus.A & bus.B;
         OP_OR:  sc_res = bus.A | bus.B;
         OP_NOR: sc_res = ~(bus.A | bus.B);
         OP_ADD: begin
            sc_res = sum;
            sc_ovf = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
         end
         OP_SUB: begin
            sc_res = diff;
            sc_ovf = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff[WIDTH-1] != bus.A[WIDTH-1]);
         end
         OP_SLL: sc_res = bus.A << bus.B[SHW-1:0];
         OP_SRL: sc_res = bus.A >> bus.B[SHW-1:0];
         OP_SLT: sc_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
         default: sc_res = '0;
      endcase
   end

   // One iteration step: hi:lo is the running product (multiplier consumed from lo[0]),
   // or remainder:quotient for the restoring divider (dividend shifted out of lo's MSB)
   always_comb begin
      mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
`ifdef ALU_DIVIDE_EN
      div_trial = {acc_hi_q, acc_lo_q[WIDTH-1]} - {1'b0, b_q};
      if (op_q == OP_DIVU) begin
         if (!div_trial[WIDTH]) begin
            step_hi = div_trial[WIDTH-1:0];
            step_lo = {acc_lo_q[WIDTH-2:0], 1'b1};
         end else begin
            step_hi = {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
            step_lo = {acc_lo_q[WIDTH-2:0], 1'b0};
         end
      end
`endif
   end

   // Operand capture, result registers and iteration counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q    <= '0;
         b_q      <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         ovf_q    <= 1'b0;
`ifdef ALU_DIVIDE_EN
         op_q     <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  b_q      <= bus.B;
                  acc_hi_q <= '0;
                  cnt_q    <= SHW'(WIDTH - 1);
`ifdef ALU_DIVIDE_EN
                  op_q     <= bus.ALUOperation;
`endif
                  if (iter_op) begin
                     acc_lo_q <= bus.A;
                     ovf_q    <= 1'b0;
                  end else begin
                     acc_lo_q <= sc_res;
                     ovf_q    <= sc_ovf;
                  end
               end
            end
            ITER: begin
               acc_hi_q <= step_hi;
               acc_lo_q <= step_lo;
               cnt_q    <= cnt_q - SHW'(1);
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.ALUResult = acc_lo_q;
   assign bus.ResultHi  = acc_hi_q;
   assign bus.Zero      = (acc_lo_q == '0);
   assign bus.Overflow  = ovf_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - vector table, corner sequences and random ops against a reference model
module tb_alu_multicycle;
   localparam int W   = 32;
   localparam int SHW = $clog2(W);

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   alu_multicycle_if #(.WIDTH(W)) bus ();
   alu_multicycle #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] lo;
      logic [W-1:0] hi;
      logic         ovf;
      int           lat;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b,
                               logic [W-1:0] lo, logic [W-1:0] hi, logic ovf, int lat);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.lo = lo; v.hi = hi; v.ovf = ovf; v.lat = lat;
      return v;
   endfunction

   // Reference: plain arithmetic on the opcode's meaning
   function automatic vec_t model(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b);
      vec_t r;
      logic [2*W-1:0] p;
      logic [W:0]     s;
      int             sh;
      r = mk(op, a, b, '0, '0, 1'b0, 1);
      sh = int'(b[SHW-1:0]);
      case (op)
         4'd0: r.lo = a & b;
         4'd1: r.lo = a | b;
         4'd2: r.lo = ~(a | b);
         4'd3: begin
            s = {a[W-1], a} + {b[W-1], b};
            r.lo = s[W-1:0];
            r.ovf = (s[W] != s[W-1]);
         end
         4'd4: begin
            s = {a[W-1], a} - {b[W-1], b};
            r.lo = s[W-1:0];
            r.ovf = (s[W] != s[W-1]);
         end
         4'd5: r.lo = a << sh;
         4'd6: r.lo = a >> sh;
         4'd7: r.lo = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
         4'd8: begin
            p = (2*W)'(a) * (2*W)'(b);
            r.lo = p[W-1:0];
            r.hi = p[2*W-1:W];
            r.lat = W + 1;
         end
`ifdef ALU_DIVIDE_EN
         4'd9: begin
            r.lat = W + 1;
            if (b == '0) begin
               r.lo = '1;
               r.hi = a;
            end else begin
               r.lo = a / b;
               r.hi = a % b;
            end
         end
`endif
         default: begin
         end
      endcase
      return r;
   endfunction

   task automatic run_op(input vec_t v, input string name);
      int   lat;
      logic busy_ok;
      lat = 0;
      while (!bus.in_ready && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      check({name, " in_ready before accept"}, 64'(bus.in_ready), 64'(1));
      bus.ALUOperation = v.op;
      bus.A = v.a;
      bus.B = v.b;
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.A = $urandom;
      bus.B = $urandom;
      bus.ALUOperation = 4'($urandom);
      lat = 1;
      busy_ok = 1'b1;
      while (!bus.out_valid && lat < 100) begin
         if (bus.in_ready) busy_ok = 1'b0;
         @(negedge clk);
         lat++;
      end
      check({name, " latency"}, 64'(lat), 64'(v.lat));
      check({name, " in_ready low while busy"}, 64'(busy_ok), 64'(1));
      check({name, " out_valid"}, 64'(bus.out_valid), 64'(1));
      check({name, " in_ready low in DONE"}, 64'(bus.in_ready), 64'(0));
      check({name, " ALUResult"}, 64'(bus.ALUResult), 64'(v.lo));
      check({name, " ResultHi"}, 64'(bus.ResultHi), 64'(v.hi));
      check({name, " Overflow"}, 64'(bus.Overflow), 64'(v.ovf));
      check({name, " Zero"}, 64'(bus.Zero), 64'(v.lo == '0));
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check({name, " out_valid drop"}, 64'(bus.out_valid), 64'(0));
      check({name, " in_ready back"}, 64'(bus.in_ready), 64'(1));
   endtask

   initial begin
      int   n;
      vec_t v;

      tbl.push_back(mk(4'd3, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h0, 1'b1, 1));
      tbl.push_back(mk(4'd4, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 32'h0, 1'b0, 1));
      tbl.push_back(mk(4'd7, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 32'h0, 1'b0, 1));
      tbl.push_back(mk(4'd6, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 32'h0, 1'b0, 1));
      tbl.push_back(mk(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 33));
      tbl.push_back(mk(4'd0, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h00F0_F000, 32'h0, 1'b0, 1));
      tbl.push_back(mk(4'd1, 32'hF0F0_0000, 32'h0000_000F, 32'hF0F0_000F, 32'h0, 1'b0, 1));
      tbl.push_back(mk(4'd2, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 1));
      tbl.push_back(mk(4'd5, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 32'h0, 1'b0, 1));
      tbl.push_back(mk(4'd5, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 32'h0, 1'b0, 1));
      tbl.push_back(mk(4'd4, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 32'h0, 1'b1, 1));
      tbl.push_back(mk(4'd3, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'h0, 1'b0, 1));
      tbl.push_back(mk(4'd7, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0, 1'b0, 1));
      tbl.push_back(mk(4'd8, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h1, 1'b0, 33));
      tbl.push_back(mk(4'd15, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 32'h0, 1'b0, 1));
`ifdef ALU_DIVIDE_EN
      tbl.push_back(mk(4'd9, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33));
      tbl.push_back(mk(4'd9, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9, 1'b0, 33));
`else
      tbl.push_back(mk(4'd9, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 1));
`endif

      // Reset state
      reset = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.ALUOperation = 4'd0;
      bus.A = '0;
      bus.B = '0;
      repeat (3) @(negedge clk);
      check("rst in_ready", 64'(bus.in_ready), 64'(0));
      check("rst out_valid", 64'(bus.out_valid), 64'(0));
      check("rst ALUResult", 64'(bus.ALUResult), 64'(0));
      check("rst ResultHi", 64'(bus.ResultHi), 64'(0));
      check("rst Zero", 64'(bus.Zero), 64'(1));
      check("rst Overflow", 64'(bus.Overflow), 64'(0));
      reset = 1'b1;
      #1;
      check("release in_ready before clk", 64'(bus.in_ready), 64'(0));
      @(negedge clk);
      check("release in_ready after clk", 64'(bus.in_ready), 64'(1));

      // Reset during MULU iteration discards the operation
      bus.ALUOperation = 4'd8;
      bus.A = 32'hFFFF_FFFF;
      bus.B = 32'hFFFF_FFFF;
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (10) @(negedge clk);
      check("mid-mulu busy", 64'(bus.in_ready), 64'(0));
      reset = 1'b0;
      #1;
      check("mid-mulu rst out_valid", 64'(bus.out_valid), 64'(0));
      check("mid-mulu rst Zero", 64'(bus.Zero), 64'(1));
      check("mid-mulu rst ResultHi", 64'(bus.ResultHi), 64'(0));
      check("mid-mulu rst in_ready", 64'(bus.in_ready), 64'(0));
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("mid-mulu release in_ready", 64'(bus.in_ready), 64'(1));
      check("mid-mulu release out_valid", 64'(bus.out_valid), 64'(0));
      run_op(mk(4'd3, 32'd2, 32'd3, 32'd5, 32'd0, 1'b0, 1), "post-reset ADD");

      // Backpressure: DONE holds outputs and ignores in_valid
      bus.ALUOperation = 4'd3;
      bus.A = 32'h10;
      bus.B = 32'h20;
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.ALUOperation = 4'd4;
      bus.A = 32'h1234;
      bus.B = 32'h1;
      n = 0;
      while (!bus.out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         check("bp out_valid", 64'(bus.out_valid), 64'(1));
         check("bp ALUResult", 64'(bus.ALUResult), 64'(32'h30));
         check("bp in_ready", 64'(bus.in_ready), 64'(0));
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("bp release out_valid", 64'(bus.out_valid), 64'(0));
      check("bp release in_ready", 64'(bus.in_ready), 64'(1));
      check("bp no queued op", 64'(bus.ALUResult), 64'(32'h30));

      // Vector table
      foreach (tbl[i]) run_op(tbl[i], $sformatf("vec%0d", i));

      // Table entries must agree with the reference model too
      foreach (tbl[i]) begin
         v = model(tbl[i].op, tbl[i].a, tbl[i].b);
         check($sformatf("model vec%0d", i), {v.lo, v.hi}, {tbl[i].lo, tbl[i].hi});
      end

      // Random ops against the reference model
      for (int k = 0; k < 150; k++) begin
         v = model(4'($urandom_range(0, 15)), $urandom, $urandom);
         run_op(v, $sformatf("rnd%0d op%0d", k, v.op));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
